// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: load/store funct3 encodings,
// data-memory controller states and the default ack timeout.
package riscv_pkg;

  localparam int DMEM_TIMEOUT = 16;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } l_func;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } s_func;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store-data
// replication and the alignment/legality check.
module mem_lane_align
  import riscv_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        legal
);

  logic known;
  logic half;
  logic word;

  always_comb begin
    known     = 1'b0;
    half      = 1'b0;
    word      = 1'b0;
    be        = 4'b1111;
    wdata_rep = wdata;
    if (we) begin
      unique case (funct3)
        SB: begin
          known     = 1'b1;
          be        = 4'b0001 << addr_lo;
          wdata_rep = {4{wdata[7:0]}};
        end
        SH: begin
          known     = 1'b1;
          half      = 1'b1;
          be        = 4'b0011 << addr_lo;
          wdata_rep = {2{wdata[15:0]}};
        end
        SW: begin
          known = 1'b1;
          word  = 1'b1;
        end
        default: known = 1'b0;
      endcase
    end else begin
      unique case (funct3)
        LB, LBU: known = 1'b1;
        LH, LHU: begin
          known = 1'b1;
          half  = 1'b1;
        end
        LW: begin
          known = 1'b1;
          word  = 1'b1;
        end
        default: known = 1'b0;
      endcase
    end
    legal = known
          & ~(half & addr_lo[0])
          & ~(word & (|addr_lo));
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one load/store at a time,
// ack timeout with sticky error, misalign trap pulse.
module data_mem_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = DMEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] drdata,
  output logic [31:0] daddr,
  output logic        misalign,
  output logic        timeout_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_e    state_q;
  mem_state_e    state_d;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic          legal;
  logic          idle;
  logic          acc;
  logic          req_ok;
  logic          req_bad;
  logic          last;

  mem_lane_align u_align (
    .we        (req_we),
    .funct3    (funct3),
    .addr_lo   (addr[1:0]),
    .wdata     (wdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .legal     (legal)
  );

  assign idle    = (state_q == IDLE);
  assign acc     = (state_q == ACCESS);
  assign req_ok  = idle & req_valid & legal;
  assign req_bad = idle & req_valid & ~legal;
  assign last    = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    done    = misalign;
    // reset gate keeps stall low while the core drives req_valid in reset
    stall   = reset & (req_ok | acc);
    unique case (state_q)
      IDLE: begin
        if (req_ok) state_d = ACCESS;
      end
      ACCESS: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        if (mem_ack || last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      we_q        <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      daddr       <= '0;
      drdata      <= '0;
      misalign    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      misalign <= req_bad;
      if (req_ok) begin
        cnt_q     <= '0;
        we_q      <= req_we;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= be;
        mem_wdata <= wdata_rep;
        daddr     <= addr;
      end else if (acc) begin
        cnt_q <= cnt_q + 1'b1;
        // ack wins over a timeout landing in the same cycle
        if (mem_ack) begin
          if (!we_q) drdata <= mem_rdata;
        end else if (last) begin
          timeout_err <= 1'b1;
          drdata      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed vector bench for data_mem_ctrl plus
// hand-written reset-abort sequence.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] drdata;
  logic [31:0] daddr;
  logic        misalign;
  logic        timeout_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .done        (done),
    .drdata      (drdata),
    .daddr       (daddr),
    .misalign    (misalign),
    .timeout_err (timeout_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic        bad;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] drd;
    logic        terr;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic we, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] rd, input int dly, input logic bad,
    input logic [3:0] be, input logic [31:0] mwd,
    input logic [31:0] drd, input logic terr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.rdata = rd; v.dly = dly; v.bad = bad; v.be = be;
    v.mwd = mwd; v.drd = drd; v.terr = terr;
    return v;
  endfunction

  task automatic run(input int idx, input vec_t v);
    int n_acc;
    int exp_acc;
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    funct3    = v.f3;
    addr      = v.addr;
    wdata     = v.wdata;
    #1;
    chk({t, " stall_req"}, {31'd0, stall}, {31'd0, ~v.bad});
    @(negedge clk);
    req_valid = 1'b0;
    if (v.bad) begin
      chk({t, " misalign"}, {31'd0, misalign}, 32'd1);
      chk({t, " done_bad"}, {31'd0, done}, 32'd1);
      chk({t, " no_req"}, {31'd0, mem_req}, 32'd0);
      chk({t, " drdata_keep"}, drdata, v.drd);
      @(negedge clk);
      chk({t, " misalign_end"}, {31'd0, misalign}, 32'd0);
      chk({t, " done_end"}, {31'd0, done}, 32'd0);
      chk({t, " no_req2"}, {31'd0, mem_req}, 32'd0);
    end else begin
      exp_acc = (v.dly < 16) ? v.dly + 1 : 16;
      n_acc = 0;
      while (mem_req && n_acc < 40) begin
        if (n_acc == 0) begin
          chk({t, " stall_acc"}, {31'd0, stall}, 32'd1);
          chk({t, " mem_we"}, {31'd0, mem_we}, {31'd0, v.we});
          chk({t, " mem_addr"}, mem_addr,
              {v.addr[31:2], 2'b00});
          chk({t, " mem_be"}, {28'd0, mem_be}, {28'd0, v.be});
          if (v.we) chk({t, " mem_wdata"}, mem_wdata, v.mwd);
        end
        chk({t, " done_early"}, {31'd0, done}, 32'd0);
        mem_ack   = (n_acc == v.dly);
        mem_rdata = v.rdata;
        @(negedge clk);
        n_acc++;
      end
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      chk({t, " acc_cycles"}, n_acc, exp_acc);
      chk({t, " done"}, {31'd0, done}, 32'd1);
      chk({t, " stall_done"}, {31'd0, stall}, 32'd0);
      chk({t, " drdata"}, drdata, v.drd);
      chk({t, " daddr"}, daddr, v.addr);
      chk({t, " timeout_err"}, {31'd0, timeout_err},
          {31'd0, v.terr});
      @(negedge clk);
      chk({t, " done_end"}, {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    funct3    = 3'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;

    tbl[0]  = mk(0, 3'b010, 32'h0010_0004, 32'h0, 32'hF1F2F3F4,
                 3, 0, 4'b1111, 32'h0, 32'hF1F2F3F4, 0);
    tbl[1]  = mk(1, 3'b000, 32'h0010_0003, 32'h0000_00A5, 32'h0,
                 1, 0, 4'b1000, 32'hA5A5A5A5, 32'hF1F2F3F4, 0);
    tbl[2]  = mk(1, 3'b001, 32'h0010_0002, 32'h0000_1234, 32'h0,
                 0, 0, 4'b1100, 32'h12341234, 32'hF1F2F3F4, 0);
    tbl[3]  = mk(0, 3'b001, 32'h0010_0001, 32'h0, 32'h0,
                 0, 1, 4'b0000, 32'h0, 32'hF1F2F3F4, 0);
    tbl[4]  = mk(0, 3'b000, 32'h0010_0003, 32'h0, 32'h11223344,
                 0, 0, 4'b1111, 32'h0, 32'h11223344, 0);
    tbl[5]  = mk(1, 3'b001, 32'h0010_0000, 32'hABCD_9876, 32'h0,
                 2, 0, 4'b0011, 32'h98769876, 32'h11223344, 0);
    tbl[6]  = mk(1, 3'b010, 32'h0010_0008, 32'hDEAD_BEEF, 32'h0,
                 0, 0, 4'b1111, 32'hDEADBEEF, 32'h11223344, 0);
    tbl[7]  = mk(1, 3'b010, 32'h0010_0006, 32'h0, 32'h0,
                 0, 1, 4'b0000, 32'h0, 32'h11223344, 0);
    tbl[8]  = mk(0, 3'b011, 32'h0010_0000, 32'h0, 32'h0,
                 0, 1, 4'b0000, 32'h0, 32'h11223344, 0);
    tbl[9]  = mk(1, 3'b100, 32'h0010_0000, 32'h0, 32'h0,
                 0, 1, 4'b0000, 32'h0, 32'h11223344, 0);
    tbl[10] = mk(0, 3'b101, 32'h0010_0006, 32'h0, 32'h55667788,
                 1, 0, 4'b1111, 32'h0, 32'h55667788, 0);
    tbl[11] = mk(0, 3'b010, 32'h0010_0010, 32'h0, 32'hCAFEF00D,
                 15, 0, 4'b1111, 32'h0, 32'hCAFEF00D, 0);
    tbl[12] = mk(0, 3'b010, 32'h0010_000C, 32'h0, 32'h99999999,
                 99, 0, 4'b1111, 32'h0, 32'h0, 1);
    tbl[13] = mk(1, 3'b000, 32'h0010_0001, 32'h0000_007E, 32'h0,
                 0, 0, 4'b0010, 32'h7E7E7E7E, 32'h0, 1);
    tbl[14] = mk(0, 3'b100, 32'h0010_0002, 32'h0, 32'h0BADCAFE,
                 0, 0, 4'b1111, 32'h0, 32'h0BADCAFE, 1);

    @(negedge clk);
    req_valid = 1'b1;
    #1;
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst misalign", {31'd0, misalign}, 32'd0);
    chk("rst timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst drdata", drdata, 32'h0);
    chk("rst daddr", daddr, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_be", {28'd0, mem_be}, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) run(i, tbl[i]);

    // reset abort in the middle of an access
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h0010_0020;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort in_access", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort stall", {31'd0, stall}, 32'd0);
    chk("abort timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("abort drdata", drdata, 32'h0);
    chk("abort daddr", daddr, 32'h0);
    @(negedge clk);
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("late_ack done", {31'd0, done}, 32'd0);
    chk("late_ack mem_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack drdata", drdata, 32'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack done2", {31'd0, done}, 32'd0);
    chk("late_ack stall", {31'd0, stall}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum ACCESS cycles to wait for mem_ack.
REQ-002 clk  input  1  system clock, rising-edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  l_func encoding for loads, s_func encoding for stores.
REQ-007 addr  input  32  byte address, rv1 + imm.
REQ-008 wdata  input  32  store data, rv2.
REQ-009 stall  output  1  core must hold PC and request.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 drdata  output  32  raw load word, consumed by the load formatter.
REQ-012 daddr  output  32  byte address of the last accepted access.
REQ-013 misalign  output  1  one-cycle pulse on a misaligned or illegal request.
REQ-014 timeout_err  output  1  sticky error flag.
REQ-015 mem_req, mem_we  output  1 each  memory request and write strobe.
REQ-016 mem_addr  output  32  word-aligned address, {addr[31:2], 2'b00}.
REQ-017 mem_be  output  4  byte enables.
REQ-018 mem_wdata  output  32  lane-replicated store data.
REQ-019 mem_rdata  input  32; mem_ack  input  1  memory read data and acknowledge.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-021 IDLE with req_valid and an aligned, legal request: register mem_addr, mem_be, mem_we, mem_wdata and daddr; go to ACCESS; counter cleared.
REQ-022 Alignment rules:
- Halfword with addr[0]=1 is misaligned.
- Word with addr[1:0]!=0 is misaligned.
- An undefined funct3 is illegal.
REQ-023 IDLE with a misaligned or illegal request: no memory access; misalign=1 and done=1 for one cycle; state stays IDLE.
REQ-024 stall SHALL equal (IDLE & req_valid & legal) | ACCESS; stall SHALL be 0 in DONE.
REQ-025 ACCESS: mem_req=1; all mem_* outputs held stable until mem_ack; counter increments each cycle.
REQ-026 ACCESS with mem_ack=1 on a load: capture mem_rdata into drdata; go to DONE.
REQ-027 ACCESS with mem_ack=1 on a store: drdata unchanged; go to DONE.
REQ-028 Counter reaching TIMEOUT without mem_ack: set timeout_err (sticky until reset); drdata=0; mem_req drops; go to DONE.
REQ-029 If mem_ack arrives in the same cycle the counter reaches TIMEOUT, mem_ack SHALL win and timeout_err SHALL stay clear.
REQ-030 DONE: done=1 for exactly one cycle; mem_req=0; unconditional return to IDLE.
REQ-031 mem_ack in IDLE or DONE SHALL be ignored.
REQ-032 Byte enables:
- SB: 4'b0001 << addr[1:0]
- SH: 4'b0011 << addr[1:0]
- SW: 4'b1111
- All loads: 4'b1111
REQ-033 Store data:
- SB: {4{wdata[7:0]}}
- SH: {2{wdata[15:0]}}
- SW: wdata
REQ-034 Minimum latency: request in cycle N, ack in cycle N+1, done in cycle N+2.

Reset
REQ-035 reset low SHALL asynchronously force state IDLE, counter 0, and every output 0 (including drdata, daddr and timeout_err), aborting any access in flight.

Structure
REQ-036 Add mem_state_e, s_func and DMEM_TIMEOUT to riscv_pkg; reuse l_func from riscv_pkg.
REQ-037 Put byte-enable and write-data replication in a combinational sub-module named mem_lane_align.

Verification
REQ-038 LW addr 0x00100004, mem_ack 3 cycles after ACCESS entry, rdata 0xF1F2F3F4 -> mem_be 1111, mem_addr 0x00100004, one done pulse, drdata 0xF1F2F3F4.
REQ-039 SB addr 0x00100003, wdata 0x000000A5 -> mem_we 1, mem_be 1000, mem_wdata 0xA5A5A5A5.
REQ-040 SH addr 0x00100002, wdata 0x00001234, ack in first ACCESS cycle -> mem_be 1100, mem_wdata 0x12341234, done two cycles after request.
REQ-041 LH addr 0x00100001 -> misalign and done pulse together, mem_req never asserted.
REQ-042 LW, mem_ack held low -> after 16 ACCESS cycles: timeout_err 1, drdata 0, done pulse; timeout_err stays 1 across later requests.
REQ-043 reset low during ACCESS -> mem_req 0 immediately, state IDLE; a subsequent mem_ack is ignored and done is not pulsed.
